// File: rtl/reg_write_scheduler_if.sv
// Write-scheduler bus: ALU writeback, load issue/return, decode sources and the
// register-file write port, with scoreboard and error status.
interface reg_write_scheduler_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int NREG   = 8
);
  logic              busywait;
  logic              alu_wr_valid;
  logic [ADDR_W-1:0] alu_wr_addr;
  logic [DATA_W-1:0] alu_wr_data;
  logic              ld_issue;
  logic [ADDR_W-1:0] ld_issue_addr;
  logic              ld_ret_valid;
  logic [DATA_W-1:0] ld_ret_data;
  logic              src_valid;
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;
  logic              stall;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_inaddress;
  logic [DATA_W-1:0] rf_in;
  logic [NREG-1:0]   pending;
  logic              err;

  modport master (
    output busywait, alu_wr_valid, alu_wr_addr, alu_wr_data,
           ld_issue, ld_issue_addr, ld_ret_valid, ld_ret_data,
           src_valid, rd1_addr, rd2_addr,
    input  stall, rf_write, rf_inaddress, rf_in, pending, err
  );

  modport slave (
    input  busywait, alu_wr_valid, alu_wr_addr, alu_wr_data,
           ld_issue, ld_issue_addr, ld_ret_valid, ld_ret_data,
           src_valid, rd1_addr, rd2_addr,
    output stall, rf_write, rf_inaddress, rf_in, pending, err
  );
endinterface

// File: rtl/reg_write_scheduler.sv
// Single-write-port scheduler for the register file: load returns take priority
// over ALU writeback; a load-tag FIFO and pending scoreboard drive the stall.
module reg_write_scheduler #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int NREG     = 8,
  parameter int LQ_DEPTH = 2
) (
  input logic CLK,
  input logic RESET,
  reg_write_scheduler_if.slave bus
);
  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = $clog2(LQ_DEPTH + 1);

  logic [ADDR_W-1:0] tag_mem [LQ_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;

  logic              rb_valid;
  logic [ADDR_W-1:0] rb_addr;
  logic [DATA_W-1:0] rb_data;

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic              err;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_data;

  logic              fifo_empty;
  logic              fifo_full;
  logic              ret_pop;
  logic              rb_write;
  logic              stall;
  logic              issue_acc;
  logic              alu_write;
  logic              rf_write;
  logic [ADDR_W-1:0] rf_inaddress;
  logic [DATA_W-1:0] rf_in;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(LQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    fifo_empty = (count == '0);
    fifo_full  = (count == CNT_W'(LQ_DEPTH));
    // A return that lands while the retbuf is still occupied is dropped and does not pop.
    ret_pop    = bus.ld_ret_valid & ~fifo_empty & ~rb_valid;
    rb_write   = rb_valid & ~bus.busywait;
    // A full FIFO still accepts an issue when the same edge pops the head.
    stall      = bus.busywait
               | rb_valid
               | (bus.ld_issue & fifo_full & ~ret_pop)
               | (bus.ld_issue & pending[bus.ld_issue_addr])
               | (bus.alu_wr_valid & pending[bus.alu_wr_addr])
               | (bus.src_valid & (pending[bus.rd1_addr] | pending[bus.rd2_addr]));
    issue_acc  = bus.ld_issue & ~stall;
    alu_write  = bus.alu_wr_valid & ~stall;
    rf_write   = rb_write | alu_write;

    rf_inaddress = last_addr;
    rf_in        = last_data;
    if (rb_write) begin
      rf_inaddress = rb_addr;
      rf_in        = rb_data;
    end else if (alu_write) begin
      rf_inaddress = bus.alu_wr_addr;
      rf_in        = bus.alu_wr_data;
    end

    pending_nxt = pending;
    if (rb_write) pending_nxt[rb_addr] = 1'b0;
    if (issue_acc) pending_nxt[bus.ld_issue_addr] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < LQ_DEPTH; i++) tag_mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rb_valid  <= 1'b0;
      rb_addr   <= '0;
      rb_data   <= '0;
      pending   <= '0;
      err       <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (issue_acc) begin
        tag_mem[wr_ptr] <= bus.ld_issue_addr;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (ret_pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({issue_acc, ret_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (ret_pop) begin
        rb_valid <= 1'b1;
        rb_addr  <= tag_mem[rd_ptr];
        rb_data  <= bus.ld_ret_data;
      end else if (rb_write) begin
        rb_valid <= 1'b0;
      end

      pending <= pending_nxt;

      if (bus.ld_ret_valid & (fifo_empty | rb_valid)) err <= 1'b1;

      if (rf_write) begin
        last_addr <= rf_inaddress;
        last_data <= rf_in;
      end
    end
  end

  assign bus.stall        = stall;
  assign bus.rf_write     = rf_write;
  assign bus.rf_inaddress = rf_inaddress;
  assign bus.rf_in        = rf_in;
  assign bus.pending      = pending;
  assign bus.err          = err;
endmodule

// File: tb/tb_reg_write_scheduler.sv
// Bench for reg_write_scheduler: directed scenarios plus random traffic, all
// checked each cycle against a queue-based reference model.
module tb_reg_write_scheduler;
  localparam int LQ = 2;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int checks = 0;
  int errors = 0;

  reg_write_scheduler_if bus ();

  reg_write_scheduler dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [2:0] tagq[$];
  bit         rb_v;
  logic [2:0] rb_a;
  logic [7:0] rb_d;
  logic [7:0] pend;
  bit         m_err;
  logic [2:0] last_a;
  logic [7:0] last_d;
  logic [7:0] rf_shadow [8];

  bit         e_stall;
  bit         e_wr;
  logic [2:0] e_a;
  logic [7:0] e_d;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    rb_v = 0; rb_a = '0; rb_d = '0;
    pend = '0; m_err = 0;
    last_a = '0; last_d = '0;
  endtask

  task automatic idle();
    bus.busywait = 0; bus.alu_wr_valid = 0; bus.alu_wr_addr = '0; bus.alu_wr_data = '0;
    bus.ld_issue = 0; bus.ld_issue_addr = '0; bus.ld_ret_valid = 0; bus.ld_ret_data = '0;
    bus.src_valid = 0; bus.rd1_addr = '0; bus.rd2_addr = '0;
  endtask

  // Expected combinational outputs from the model, then compare at the falling edge.
  task automatic settle();
    bit can_pop;
    can_pop = bus.ld_ret_valid && tagq.size() > 0 && !rb_v;
    e_stall = bus.busywait || rb_v
            || (bus.ld_issue && tagq.size() >= LQ && !can_pop)
            || (bus.ld_issue && pend[bus.ld_issue_addr])
            || (bus.alu_wr_valid && pend[bus.alu_wr_addr])
            || (bus.src_valid && (pend[bus.rd1_addr] || pend[bus.rd2_addr]));
    if (rb_v && !bus.busywait) begin
      e_wr = 1; e_a = rb_a; e_d = rb_d;
    end else if (bus.alu_wr_valid && !e_stall) begin
      e_wr = 1; e_a = bus.alu_wr_addr; e_d = bus.alu_wr_data;
    end else begin
      e_wr = 0; e_a = last_a; e_d = last_d;
    end
    @(negedge CLK);
    chk("stall", bus.stall, e_stall);
    chk("rf_write", bus.rf_write, e_wr);
    chk("rf_inaddress", bus.rf_inaddress, e_a);
    chk("rf_in", bus.rf_in, e_d);
    chk("pending", bus.pending, pend);
    chk("err", bus.err, m_err);
    if (bus.rf_write) rf_shadow[bus.rf_inaddress] = bus.rf_in;
  endtask

  task automatic advance();
    bit old_v;
    @(posedge CLK);
    old_v = rb_v;
    if (e_wr) begin last_a = e_a; last_d = e_d; end
    if (rb_v && !bus.busywait) begin pend[rb_a] = 0; rb_v = 0; end
    if (bus.ld_ret_valid) begin
      if (tagq.size() == 0 || old_v) m_err = 1;
      else begin
        rb_a = tagq.pop_front(); rb_d = bus.ld_ret_data; rb_v = 1;
      end
    end
    if (bus.ld_issue && !e_stall) begin
      tagq.push_back(bus.ld_issue_addr);
      pend[bus.ld_issue_addr] = 1;
    end
    #1;
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic issue(input logic [2:0] a);
    idle(); bus.ld_issue = 1; bus.ld_issue_addr = a;
  endtask

  task automatic ret(input logic [7:0] d);
    idle(); bus.ld_ret_valid = 1; bus.ld_ret_data = d;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf_shadow[i] = '0;
    idle();
    model_reset();
    repeat (2) @(negedge CLK);
    chk("reset_pending", bus.pending, 0);
    chk("reset_rf_write", bus.rf_write, 0);
    chk("reset_stall", bus.stall, 0);
    chk("reset_err", bus.err, 0);
    RESET = 1;
    @(posedge CLK); #1;

    // Basic load: r2 <= 0xA5, written one cycle after the return
    issue(3'd2); step();
    ret(8'hA5); settle(); chk("basic_pend2", bus.pending[2], 1); advance();
    idle(); settle();
    chk("basic_wr", bus.rf_write, 1);
    chk("basic_addr", bus.rf_inaddress, 2);
    chk("basic_data", bus.rf_in, 8'hA5);
    advance();
    settle(); chk("basic_pend_clr", bus.pending[2], 0); advance();

    // Collision: retbuf r1 vs ALU r4
    issue(3'd1); step();
    ret(8'h11); step();
    idle(); bus.alu_wr_valid = 1; bus.alu_wr_addr = 3'd4; bus.alu_wr_data = 8'h22;
    settle();
    chk("coll_load_addr", bus.rf_inaddress, 1);
    chk("coll_stall", bus.stall, 1);
    advance();
    settle();
    chk("coll_alu_wr", bus.rf_write, 1);
    chk("coll_alu_addr", bus.rf_inaddress, 4);
    chk("coll_stall2", bus.stall, 0);
    advance();
    idle(); step();
    chk("coll_rf1", rf_shadow[1], 8'h11);
    chk("coll_rf4", rf_shadow[4], 8'h22);

    // RAW on r5
    issue(3'd5); step();
    idle(); bus.src_valid = 1; bus.rd1_addr = 3'd5; bus.rd2_addr = 3'd0;
    settle(); chk("raw_stall", bus.stall, 1); advance();
    bus.ld_ret_valid = 1; bus.ld_ret_data = 8'h55;
    settle(); chk("raw_stall_ret", bus.stall, 1); advance();
    bus.ld_ret_valid = 0;
    settle(); chk("raw_write", bus.rf_inaddress, 5); chk("raw_stall_wr", bus.stall, 1); advance();
    settle(); chk("raw_release", bus.stall, 0); advance();

    // FIFO full, then simultaneous return and issue
    issue(3'd0); step();
    issue(3'd6); step();
    issue(3'd7); settle(); chk("full_stall", bus.stall, 1); advance();
    bus.ld_ret_valid = 1; bus.ld_ret_data = 8'hB0;
    settle(); chk("full_pushpop", bus.stall, 0); advance();
    idle(); settle();
    chk("full_wr0", bus.rf_inaddress, 0);
    chk("full_pend", bus.pending, 8'b1100_0001);
    advance();
    ret(8'hB6); step();
    idle(); settle(); chk("full_wr6", bus.rf_inaddress, 6); advance();
    ret(8'hB7); step();
    idle(); settle(); chk("full_wr7", bus.rf_in, 8'hB7); advance();
    settle(); chk("full_empty", bus.pending, 0); advance();

    // busywait holds the retbuf
    issue(3'd3); step();
    ret(8'h3C); step();
    idle(); bus.busywait = 1;
    settle(); chk("busy_nowr", bus.rf_write, 0); chk("busy_stall", bus.stall, 1); advance();
    bus.busywait = 0;
    settle(); chk("busy_wr", bus.rf_write, 1); chk("busy_data", bus.rf_in, 8'h3C); advance();
    idle(); step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      bus.busywait      = ($urandom_range(0, 3) == 0);
      bus.alu_wr_valid  = $urandom_range(0, 1) != 0;
      bus.alu_wr_addr   = 3'($urandom_range(0, 7));
      bus.alu_wr_data   = 8'($urandom_range(0, 255));
      bus.ld_issue      = ($urandom_range(0, 2) == 0);
      bus.ld_issue_addr = 3'($urandom_range(0, 7));
      bus.ld_ret_valid  = (tagq.size() > 0) && !rb_v && ($urandom_range(0, 1) != 0);
      bus.ld_ret_data   = 8'($urandom_range(0, 255));
      bus.src_valid     = $urandom_range(0, 1) != 0;
      bus.rd1_addr      = 3'($urandom_range(0, 7));
      bus.rd2_addr      = 3'($urandom_range(0, 7));
      step();
    end

    // Reset mid-load: r3 outstanding, then a stray return flags err
    idle();
    for (int n = 0; n < 6; n++) step();
    issue(3'd3); step();
    idle();
    #2 RESET = 0;
    #1;
    chk("rst_pending", bus.pending, 0);
    chk("rst_rf_write", bus.rf_write, 0);
    chk("rst_stall", bus.stall, 0);
    model_reset();
    @(negedge CLK); RESET = 1;
    @(posedge CLK); #1;
    ret(8'h99); step();
    idle(); settle(); chk("rst_err", bus.err, 1); chk("rst_no_wr", bus.rf_write, 0); advance();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
